// File: rtl/br_seq_pkg.sv
// Shared types and constants for the duplex buffer register (BR) load-cycle sequencer.
package br_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_STROBE,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } br_state_t;

    localparam int SIDE_A = 0;
    localparam int SIDE_B = 1;

    // BRA/BRB carry BR bits {14,12,9,6}, MSB first
    localparam int BR_BIT6  = 0;
    localparam int BR_BIT9  = 1;
    localparam int BR_BIT12 = 2;
    localparam int BR_BIT14 = 3;

endpackage

// File: rtl/br_duplex_compare.sv
// A/B half compare of the BR, sampled in the CHECK state; holds MISCOMP and a sticky error.
module br_duplex_compare
    import br_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] bra,
    input  logic [3:0] brb,
    input  logic       both_en,
    input  logic       check,
    input  logic       err_clr,
    output logic       miscomp,
    output logic       err_sticky
);

    logic [3:0] diff;
    logic       mismatch;

    assign diff     = bra ^ brb;
    assign mismatch = |{diff[BR_BIT14], diff[BR_BIT12], diff[BR_BIT9], diff[BR_BIT6]};

    // A fresh miscompare outranks ERR_CLR in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            miscomp    <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            if (check) begin
                miscomp <= both_en && mismatch;
            end
            if (check && both_en && mismatch) begin
                err_sticky <= 1'b1;
            end else if (err_clr) begin
                err_sticky <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/br_cycle_sequencer.sv
// BR load-cycle sequencer: clear, sense/transfer strobe, settle, optional duplex check, done.
// Define BR_DUPLEX_COMPARE_EN to build in the CHECK state, MISCOMP and ERR_STICKY.
module br_cycle_sequencer
    import br_seq_pkg::*;
#(
    parameter int CLEAR_CYCLES = 1,
    parameter int SENSE_CYCLES = 2
) (
    input  logic       SIM_CLK,
    input  logic       SIM_RST,
    input  logic       START,
    input  logic       XFER,
    input  logic [1:0] MSEL,
    input  logic [1:0] SIDE_EN,
    input  logic [3:0] BRA,
    input  logic [3:0] BRB,
    input  logic       ERR_CLR,
    output logic       A1CBRVN,
    output logic       A2CBRVN,
    output logic       A1SBRXV,
    output logic       A2SBRXV,
    output logic       A1PARV,
    output logic       A2PARV,
    output logic [7:0] SENSE_EN,
    output logic       BUSY,
    output logic       DONE,
    output logic       MISCOMP,
    output logic       ERR_STICKY
);

    localparam logic [2:0] CLEAR_LAST = 3'(CLEAR_CYCLES - 1);
    localparam logic [2:0] SENSE_LAST = 3'(SENSE_CYCLES - 1);

    br_state_t  state;
    br_state_t  state_nxt;
    logic [2:0] cnt;
    logic       xfer_q;
    logic [1:0] msel_q;
    logic [1:0] side_q;
    logic       accept;
    logic       xfer_nxt;
    logic [1:0] msel_nxt;
    logic [1:0] side_nxt;
    logic       clear_nxt;
    logic       strobe_nxt;

    function automatic br_state_t next_state(input br_state_t s, input logic start,
                                             input logic [2:0] c);
        case (s)
            ST_IDLE:   return start ? ST_CLEAR : ST_IDLE;
            ST_CLEAR:  return (c == CLEAR_LAST) ? ST_STROBE : ST_CLEAR;
            ST_STROBE: return (c == SENSE_LAST) ? ST_SETTLE : ST_STROBE;
`ifdef BR_DUPLEX_COMPARE_EN
            ST_SETTLE: return ST_CHECK;
            ST_CHECK:  return ST_DONE;
`else
            ST_SETTLE: return ST_DONE;
`endif
            default:   return ST_IDLE;
        endcase
    endfunction

    function automatic logic [7:0] sense_mask(input logic [1:0] msel, input logic [1:0] side);
        logic [7:0] m;
        m = '0;
        m[{msel, 1'b0}] = side[SIDE_A];
        m[{msel, 1'b1}] = side[SIDE_B];
        return m;
    endfunction

    // Outputs are registered from the upcoming state, so a freshly accepted
    // request must use the live XFER/MSEL/SIDE_EN rather than the latched copy.
    assign accept     = (state == ST_IDLE) && START;
    assign state_nxt  = next_state(state, START, cnt);
    assign xfer_nxt   = accept ? XFER : xfer_q;
    assign msel_nxt   = accept ? MSEL : msel_q;
    assign side_nxt   = accept ? SIDE_EN : side_q;
    assign clear_nxt  = (state_nxt == ST_CLEAR);
    assign strobe_nxt = (state_nxt == ST_STROBE);

    always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
        if (SIM_RST) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            xfer_q   <= 1'b0;
            msel_q   <= '0;
            side_q   <= '0;
            A1CBRVN  <= 1'b1;
            A2CBRVN  <= 1'b1;
            A1SBRXV  <= 1'b0;
            A2SBRXV  <= 1'b0;
            A1PARV   <= 1'b0;
            A2PARV   <= 1'b0;
            SENSE_EN <= '0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state || state == ST_IDLE) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 3'd1;
            end
            if (accept) begin
                xfer_q <= XFER;
                msel_q <= MSEL;
                side_q <= SIDE_EN;
            end
            A1CBRVN  <= !(clear_nxt && side_nxt[SIDE_A]);
            A2CBRVN  <= !(clear_nxt && side_nxt[SIDE_B]);
            A1SBRXV  <= strobe_nxt && xfer_nxt && side_nxt[SIDE_A];
            A2SBRXV  <= strobe_nxt && xfer_nxt && side_nxt[SIDE_B];
            A1PARV   <= strobe_nxt && !xfer_nxt && side_nxt[SIDE_A];
            A2PARV   <= strobe_nxt && !xfer_nxt && side_nxt[SIDE_B];
            SENSE_EN <= (strobe_nxt && !xfer_nxt) ? sense_mask(msel_nxt, side_nxt) : 8'h00;
            BUSY     <= (state_nxt != ST_IDLE);
            DONE     <= (state_nxt == ST_DONE);
        end
    end

`ifdef BR_DUPLEX_COMPARE_EN
    logic check;
    assign check = (state == ST_CHECK);

    br_duplex_compare u_compare (
        .clk        (SIM_CLK),
        .rst        (SIM_RST),
        .bra        (BRA),
        .brb        (BRB),
        .both_en    (&side_q),
        .check      (check),
        .err_clr    (ERR_CLR),
        .miscomp    (MISCOMP),
        .err_sticky (ERR_STICKY)
    );
`else
    logic unused_inputs;
    assign unused_inputs = ^{BRA, BRB, ERR_CLR};
    assign MISCOMP       = 1'b0;
    assign ERR_STICKY    = 1'b0;
`endif

endmodule

// File: doc/br_cycle_sequencer.md
# br_cycle_sequencer

Sequencer for the duplex buffer register (BR bits 6/9/12/14, A and B halves). It runs each BR load cycle: clear both halves, strobe the selected memory module pair's sense amplifiers or the transfer-register path, let the halves settle, then compare A against B. It sits between the memory-cycle timing logic and the buffer register. Its outputs drive the BR clear, set-from-TR, parity-load and sense-strobe gating, and it flags duplex disagreement.

## Interface
Parameters:
- CLEAR_CYCLES, 1: cycles the clear-low (CBRVN) pulse is held; legal range 1–4.
- SENSE_CYCLES, 2: cycles a sense or transfer strobe is held; legal range 1–7.

Ports (the clock is SIM_CLK; SIM_RST is asynchronous and active-high):
- SIM_CLK  in  1  system clock.
- SIM_RST  in  1  asynchronous active-high reset.
- START  in  1  request a BR load cycle; sampled only in IDLE.
- XFER  in  1  sampled with START. 1 = load from transfer register (SBRXV path); 0 = load from memory.
- MSEL  in  2  module pair, sampled with START. Pair k = module 2k (A side) and module 2k+1 (B side).
- SIDE_EN  in  2  bit0 = A side enabled, bit1 = B side enabled; sampled with START.
- BRA  in  4  A-half BR bits {14,12,9,6}.
- BRB  in  4  B-half BR bits {14,12,9,6}.
- ERR_CLR  in  1  clears ERR_STICKY.
- A1CBRVN, A2CBRVN  out  1 each  active-low BR clear, A and B.
- A1SBRXV, A2SBRXV  out  1 each  set BR from transfer register, A and B.
- A1PARV, A2PARV  out  1 each  parity-bit load strobe, A and B.
- SENSE_EN  out  8  per-module sense strobe; bit m = module m.
- BUSY  out  1  high from the cycle after START is accepted through the DONE cycle.
- DONE  out  1  one-cycle completion pulse.
- MISCOMP  out  1  duplex miscompare for the cycle just completed; valid while DONE is high.
- ERR_STICKY  out  1  latched miscompare.

## Operation
- States: IDLE → CLEAR → STROBE → SETTLE → CHECK → DONE → IDLE.
- IDLE: START=1 accepts a cycle and latches XFER, MSEL and SIDE_EN. START is ignored in every other state and is not queued.
- CLEAR: xCBRVN=0 for enabled sides only, held for CLEAR_CYCLES cycles.
- STROBE: held for SENSE_CYCLES cycles, enabled sides only.
  - XFER=0: SENSE_EN[2·MSEL] (A side) and SENSE_EN[2·MSEL+1] (B side) high, and xPARV high.
  - XFER=1: xSBRXV high. SENSE_EN stays 0 and PARV stays 0.
- SETTLE: one cycle with all strobes low.
- CHECK: one cycle. MISCOMP register = (BRA≠BRB) only when both sides are enabled, otherwise 0. ERR_STICKY sets when MISCOMP sets.
- DONE: DONE=1 for one cycle, then return to IDLE. A START in the DONE cycle is ignored.
- SIDE_EN=00: the cycle still runs through every state with no strobes asserted, and MISCOMP=0.
- ERR_CLR and a miscompare in the same cycle: the set wins, so ERR_STICKY=1.
- MISCOMP holds its value until the next CHECK state.
- Phase counter width is 3 bits. No wrap-around can occur within the legal parameter ranges.

## Timing
- Reset values: A1CBRVN=A2CBRVN=1; SBRXV, PARV and SENSE_EN all 0; BUSY=DONE=MISCOMP=ERR_STICKY=0; state IDLE.
- SIM_RST assertion mid-cycle: all outputs go to reset values immediately, asynchronously, and any in-flight cycle is abandoned.
- START sampled at edge n gives:
  - CLEAR in cycles n+1 … n+CLEAR_CYCLES.
  - STROBE in the next SENSE_CYCLES cycles.
  - Then one SETTLE cycle, one CHECK cycle, one DONE cycle.
- Defaults, with the duplex-compare feature compiled in: CLEAR n+1, STROBE n+2..n+3, SETTLE n+4, CHECK n+5, DONE n+6. Total latency from START to DONE is 6 cycles.
- Back-to-back cycles: the earliest next accepted START is the cycle after DONE.
- All outputs are registered; none is combinational from an input.

## Configuration
- BR_DUPLEX_COMPARE_EN defined: the CHECK state exists, and MISCOMP and ERR_STICKY behave as described above.
- BR_DUPLEX_COMPARE_EN undefined:
  - The CHECK state is removed: SETTLE goes directly to DONE, so default latency is 5 cycles.
  - MISCOMP and ERR_STICKY are tied to 0.
  - BRA, BRB and ERR_CLR are unused.

## Structure
- Package br_seq_pkg contains:
  - the state enumeration type;
  - the side-index constants SIDE_A=0 and SIDE_B=1;
  - the bit-position constants for BR bits 6/9/12/14 within BRA/BRB.
- One sub-module, br_duplex_compare, compiled only under BR_DUPLEX_COMPARE_EN.
  - Inputs: BRA, BRB, both-sides-enabled, check strobe, ERR_CLR.
  - Outputs: the MISCOMP and ERR_STICKY registers.

## Test plan
- START with MSEL=2, XFER=0, SIDE_EN=11, BRA=BRB=4'hA:
  - A1CBRVN=A2CBRVN=0 in n+1;
  - SENSE_EN=8'h30 and both PARV high in n+2..n+3;
  - DONE in n+6 with MISCOMP=0.
- START with XFER=1, SIDE_EN=01 → A1SBRXV=1 in n+2..n+3; A2SBRXV, A2CBRVN=1 and SENSE_EN stay inactive throughout.
- BRA=4'h5, BRB=4'h4 during CHECK → MISCOMP=1 and ERR_STICKY=1 at DONE. A later ERR_CLR clears ERR_STICKY to 0, and MISCOMP stays 1 until the next CHECK.
- START pulsed at n+3 and again in the DONE cycle n+6 → both ignored; a START at n+7 is accepted.
- SIM_RST asserted during STROBE → strobes drop to 0 and CBRVN to 1 before the next edge; BUSY=0; state IDLE.
- Parameters CLEAR_CYCLES=2, SENSE_CYCLES=3 → DONE in n+8; with BR_DUPLEX_COMPARE_EN undefined, DONE in n+7 and MISCOMP=0.
